// File: rtl/led_pio_pkg.sv
// Shared types and constants for the LED PIO scheduler.
package led_pio_pkg;

    // Transaction phases: arbitrate, read PIO, write merged value, acknowledge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } state_t;

    // The PIO data register sits at offset 0 of the slave.
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    // Width of the Avalon-MM data bus to the PIO slave.
    localparam int PIO_BUS_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr with wrap.
// The pointer register lives in the parent so it only moves on completion.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             enable,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Walk offsets from the far end down to ptr so the nearest requester
    // at or above ptr is the last (and therefore winning) assignment.
    always_comb begin : arb
        int idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (enable) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = (int'(ptr) + k) % NREQ;
                if (req[idx]) begin
                    grant       = '0;
                    grant[idx]  = 1'b1;
                    grant_idx   = PTR_W'(idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/led_pio_sched.sv
// Round-robin scheduler sharing the LED PIO slave between requesters.
// Each grant performs a read-modify-write so requesters only touch the
// LED bits enabled in their mask.
module led_pio_sched
    import led_pio_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int LED_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*LED_W-1:0] req_data,
    input  logic [NREQ*LED_W-1:0] req_mask,
    output logic [1:0]            pio_address,
    output logic                  pio_chipselect,
    output logic                  pio_write_n,
    output logic [PIO_BUS_W-1:0]  pio_writedata,
    input  logic [PIO_BUS_W-1:0]  pio_readdata,
    output logic [LED_W-1:0]      led_shadow,
    output logic                  busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] g_idx;
    logic [NREQ-1:0]  g_oh;
    logic [LED_W-1:0] lat_data, lat_mask, rd, merged;

    logic [NREQ-1:0]  arb_grant;
    logic [PTR_W-1:0] arb_idx;
    logic             arb_valid;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr),
        .enable      (state == IDLE),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Only the low LED_W bits of the PIO read bus carry LED state.
    generate
        if (LED_W < PIO_BUS_W) begin : g_rd_hi
            logic unused_rd_hi;
            assign unused_rd_hi = ^pio_readdata[PIO_BUS_W-1:LED_W];
        end
    endgenerate

    // Keep bits outside the mask from the PIO, take masked bits from the requester.
    assign merged      = (rd & ~lat_mask) | (lat_data & lat_mask);
    assign pio_address = PIO_DATA_ADDR;
    assign busy        = (state != IDLE);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and bus/handshake outputs, decoded from the current phase.
    always_comb begin
        state_nxt      = state;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_writedata  = '0;
        req_ready      = '0;
        case (state)
            IDLE: begin
                if (arb_valid) state_nxt = READ;
            end
            READ: begin
                pio_chipselect = 1'b1;
                state_nxt      = WRITE;
            end
            WRITE: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_writedata  = PIO_BUS_W'(merged);
                state_nxt      = ACK;
            end
            ACK: begin
                req_ready = g_oh;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the grant at arbitration, capture the PIO value,
    // track what was written, and advance the pointer past the served requester.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= '0;
            g_idx      <= '0;
            g_oh       <= '0;
            lat_data   <= '0;
            lat_mask   <= '0;
            rd         <= '0;
            led_shadow <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        g_idx    <= arb_idx;
                        g_oh     <= arb_grant;
                        lat_data <= req_data[int'(arb_idx)*LED_W +: LED_W];
                        lat_mask <= req_mask[int'(arb_idx)*LED_W +: LED_W];
                    end
                end
                READ:  rd         <= pio_readdata[LED_W-1:0];
                WRITE: led_shadow <= merged;
                ACK:   ptr        <= (int'(g_idx) == NREQ - 1) ? '0 : g_idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pio_sched.sv
// Bench for led_pio_sched: a bus-level PIO slave, a transaction model that
// predicts every output each cycle, and directed scenarios with literal checks.
module tb_led_pio_sched;

    localparam int NREQ  = 2;
    localparam int LED_W = 4;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*LED_W-1:0] req_data = '0;
    logic [NREQ*LED_W-1:0] req_mask = '0;
    logic [1:0]            pio_address;
    logic                  pio_chipselect;
    logic                  pio_write_n;
    logic [31:0]           pio_writedata;
    logic [31:0]           pio_readdata;
    logic [LED_W-1:0]      led_shadow;
    logic                  busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_pio_sched #(.NREQ(NREQ), .LED_W(LED_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .req_mask       (req_mask),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .led_shadow     (led_shadow),
        .busy           (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- PIO slave: zero wait states, preloadable when idle
    logic [LED_W-1:0] pio_reg = '0;
    logic [LED_W-1:0] pre_val = '0;
    logic             pre_en  = 1'b0;

    // Upper bus bits carry junk so a design using them is caught.
    assign pio_readdata = {28'hBADCAFE, pio_reg};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           pio_reg <= '0;
        else if (pio_chipselect && !pio_write_n) pio_reg <= pio_writedata[LED_W-1:0];
        else if (pre_en)                         pio_reg <= pre_val;
    end

    // ---------------- Transaction model
    // m_step counts cycles since a grant (0 = no transaction in flight).
    int               m_step = 0;
    int               m_g    = 0;
    int               m_ptr  = 0;
    logic [LED_W-1:0] m_data = '0, m_mask = '0, m_rd = '0, m_shadow = '0;

    function automatic int pick(input int p, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    function automatic logic [LED_W-1:0] merge(input logic [LED_W-1:0] old_v, d, m);
        return (old_v & ~m) | (d & m);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_step <= 0; m_g <= 0; m_ptr <= 0;
            m_data <= '0; m_mask <= '0; m_rd <= '0; m_shadow <= '0;
        end else begin
            case (m_step)
                0: if (req_valid != '0) begin
                    m_g    <= pick(m_ptr, req_valid);
                    m_data <= req_data[pick(m_ptr, req_valid)*LED_W +: LED_W];
                    m_mask <= req_mask[pick(m_ptr, req_valid)*LED_W +: LED_W];
                    m_step <= 1;
                end
                1: begin m_rd <= pio_reg; m_step <= 2; end
                2: begin m_shadow <= merge(m_rd, m_data, m_mask); m_step <= 3; end
                default: begin m_ptr <= (m_g + 1) % NREQ; m_step <= 0; end
            endcase
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        chk("busy",     32'(busy),           32'(m_step != 0));
        chk("cs",       32'(pio_chipselect), 32'(m_step == 1 || m_step == 2));
        chk("write_n",  32'(pio_write_n),    32'(m_step != 2));
        chk("wdata",    pio_writedata,       (m_step == 2) ? 32'(merge(m_rd, m_data, m_mask)) : 32'd0);
        chk("ready",    32'(req_ready),      (m_step == 3) ? (32'd1 << m_g) : 32'd0);
        chk("shadow",   32'(led_shadow),     32'(m_shadow));
        chk("address",  32'(pio_address),    32'd0);
    end

    // ---------------- Stimulus helpers
    task automatic drive(input int r, input logic v, input logic [LED_W-1:0] d, input logic [LED_W-1:0] m);
        req_valid[r]                = v;
        req_data[r*LED_W +: LED_W]  = d;
        req_mask[r*LED_W +: LED_W]  = m;
    endtask

    task automatic preload(input logic [LED_W-1:0] v);
        @(negedge clk);
        pre_val = v;
        pre_en  = 1'b1;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    // Wait up to budget cycles for a ready pulse; returns the requester index.
    task automatic wait_ready(input string nm, input int budget, output int idx);
        idx = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                idx = req_ready[1] ? 1 : 0;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL %s: no req_ready within %0d cycles", nm, budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, cnt, last, start;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy),           32'd0);
        chk("rst_cs",     32'(pio_chipselect), 32'd0);
        chk("rst_wn",     32'(pio_write_n),    32'd1);
        chk("rst_wdata",  pio_writedata,       32'd0);
        chk("rst_ready",  32'(req_ready),      32'd0);
        chk("rst_shadow", 32'(led_shadow),     32'd0);
        #2 reset_n = 1'b1;

        // Single request, exact latency.
        @(negedge clk);
        drive(0, 1'b1, 4'hA, 4'hF);
        @(negedge clk);
        chk("t1_read_cs", 32'(pio_chipselect), 32'd1);
        chk("t1_read_wn", 32'(pio_write_n),    32'd1);
        @(negedge clk);
        chk("t1_write_wn", 32'(pio_write_n), 32'd0);
        chk("t1_write_wd", pio_writedata,    32'h0000000A);
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'b01);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1_idle",     32'(busy),       32'd0);
        chk("t1_shadow",   32'(led_shadow), 32'hA);
        chk("t1_model",    32'(m_shadow),   32'hA);

        // Masked merge on a PIO preloaded with 5.
        preload(4'h5);
        drive(1, 1'b1, 4'hA, 4'h3);
        wait_ready("t2_wait", 8, idx);
        chk("t2_idx", 32'(idx), 32'd1);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("t2_shadow", 32'(led_shadow), 32'h6);
        chk("t2_pio",    32'(pio_reg),    32'h6);
        chk("t2_model",  32'(m_shadow),   32'h6);

        // Late data change and dropped valid after grant.
        drive(0, 1'b1, 4'h3, 4'hF);
        @(negedge clk);
        drive(0, 1'b0, 4'hF, 4'hF);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (req_ready[0]) cnt++;
        end
        chk("t3_pulses", 32'(cnt),        32'd1);
        chk("t3_shadow", 32'(led_shadow), 32'h3);

        // mask = 0 rewrites the PIO value unchanged.
        preload(4'hC);
        drive(1, 1'b1, 4'h5, 4'h0);
        wait_ready("t4_wait", 8, idx);
        chk("t4_idx", 32'(idx), 32'd1);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("t4_shadow", 32'(led_shadow), 32'hC);
        chk("t4_model",  32'(m_shadow),   32'hC);

        // Round robin with both requesters held valid.
        @(negedge clk);
        drive(0, 1'b1, 4'h1, 4'hF);
        drive(1, 1'b1, 4'h2, 4'hF);
        start = cyc;
        last  = cyc;
        for (int n = 0; n < 4; n++) begin
            wait_ready("rr_wait", 8, idx);
            chk("rr_idx", 32'(idx), 32'(n % 2));
            if (n == 0) chk("rr_first_lat", 32'(cyc - start), 32'd3);
            else        chk("rr_spacing",   32'(cyc - last),  32'd4);
            last = cyc;
            if (n == 3) req_valid = '0;
        end
        @(negedge clk);
        chk("rr_shadow", 32'(led_shadow), 32'h2);

        // Reset in the middle of a write; ptr must come back to 0.
        drive(0, 1'b1, 4'h7, 4'hF);
        wait_ready("t6_pre", 8, idx);
        req_valid[0] = 1'b0;
        drive(1, 1'b1, 4'h9, 4'hF);
        for (int i = 0; i < 8 && pio_write_n; i++) @(negedge clk);
        chk("t6_in_write", 32'(pio_write_n), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_busy",   32'(busy),           32'd0);
        chk("t6_cs",     32'(pio_chipselect), 32'd0);
        chk("t6_wn",     32'(pio_write_n),    32'd1);
        chk("t6_wdata",  pio_writedata,       32'd0);
        chk("t6_ready",  32'(req_ready),      32'd0);
        chk("t6_shadow", 32'(led_shadow),     32'd0);
        req_valid = '0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (req_ready != '0) cnt++;
        end
        chk("t6_no_ack", 32'(cnt), 32'd0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 4'h4, 4'hF);
        drive(1, 1'b1, 4'h8, 4'hF);
        wait_ready("t6_post0", 8, idx);
        chk("t6_ptr0", 32'(idx), 32'd0);
        req_valid[0] = 1'b0;
        wait_ready("t6_post1", 8, idx);
        chk("t6_next", 32'(idx), 32'd1);
        req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_shadow_end", 32'(led_shadow), 32'h8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
